// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared encodings and defaults for the F-stage PC controller.
package fetch_pc_ctrl_pkg;

    typedef enum logic [2:0] {
        NPC_SEQ = 3'b000,
        NPC_OFF = 3'b001,
        NPC_J   = 3'b010,
        NPC_JR  = 3'b011
    } npc_op_e;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_WAIT_REDIR = 2'd1,
        ST_EXC_BUBBLE = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;
    localparam logic [31:0] IMEM_LO_DEF    = 32'h0000_3000;
    localparam logic [31:0] IMEM_HI_DEF    = 32'h0000_6ffc;
    localparam logic [4:0]  EXC_CODE_ADEL  = 5'd4;

    // Opcodes 100-111 fall through to sequential fetch.
    function automatic logic is_redirect(input logic [2:0] op);
        return (op == NPC_OFF) || (op == NPC_J) || (op == NPC_JR);
    endfunction

endpackage

// File: rtl/fetch_pc_ctrl_npc_target_calc.sv
// Combinational redirect target for the D-stage branch/jump.
module npc_target_calc
    import fetch_pc_ctrl_pkg::*;
(
    input  logic [2:0]  npc_op,
    input  logic [31:0] d_pc,
    input  logic [15:0] imm_off,
    input  logic [25:0] imm_j,
    input  logic [31:0] jr,
    output logic [31:0] target
);

    always_comb begin
        target = d_pc + 32'd4;
        case (npc_op)
            NPC_OFF: target = d_pc + 32'd4 + {{14{imm_off[15]}}, imm_off, 2'b00};
            NPC_J:   target = {d_pc[31:28], imm_j, 2'b00};
            NPC_JR:  target = jr;
            default: target = d_pc + 32'd4;
        endcase
    end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// F-stage PC register and next-PC sequencing; FETCH_ADEL_CHECK_EN enables
// the fetch address-error comparators on f_exc_adel.
module fetch_pc_ctrl
    import fetch_pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
`ifdef FETCH_ADEL_CHECK_EN
    parameter logic [31:0] IMEM_LO    = IMEM_LO_DEF,
    parameter logic [31:0] IMEM_HI    = IMEM_HI_DEF,
`endif
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [2:0]  d_npc_op,
    input  logic [31:0] d_pc,
    input  logic [15:0] d_imm_off,
    input  logic [25:0] d_imm_j,
    input  logic [31:0] d_jr,
    input  logic        eret_req,
    input  logic        exc_req,
    input  logic [31:0] epc,
    input  logic        imem_ready,
    output logic [31:0] f_pc,
    output logic        f_valid,
    output logic        flush_fd,
    output logic        f_exc_adel
);

    fetch_state_e state, state_nxt;
    logic [31:0]  pc_nxt, pend_pc, pend_nxt, target;

    npc_target_calc u_target (
        .npc_op  (d_npc_op),
        .d_pc    (d_pc),
        .imm_off (d_imm_off),
        .imm_j   (d_imm_j),
        .jr      (d_jr),
        .target  (target)
    );

    always_comb begin
        state_nxt = state;
        pc_nxt    = f_pc;
        pend_nxt  = pend_pc;
        flush_fd  = 1'b0;
        if (exc_req) begin
            pc_nxt    = EXC_VECTOR;
            pend_nxt  = '0;
            state_nxt = ST_EXC_BUBBLE;
            flush_fd  = 1'b1;
        end else if (state == ST_EXC_BUBBLE) begin
            // D was just flushed, so nothing else can be acting this cycle.
            state_nxt = ST_RUN;
        end else if (eret_req) begin
            pc_nxt    = epc;
            pend_nxt  = '0;
            state_nxt = ST_RUN;
            flush_fd  = 1'b1;
        end else if (is_redirect(d_npc_op) && !stall) begin
            if (imem_ready) begin
                pc_nxt    = target;
                state_nxt = ST_RUN;
            end else begin
                pend_nxt  = target;
                state_nxt = ST_WAIT_REDIR;
            end
        end else if (!stall && imem_ready) begin
            if (state == ST_WAIT_REDIR) begin
                pc_nxt    = pend_pc;
                state_nxt = ST_RUN;
            end else begin
                pc_nxt    = f_pc + 32'd4;
            end
        end
        if (reset) flush_fd = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_RUN;
            f_pc    <= RESET_PC;
            pend_pc <= '0;
        end else begin
            state   <= state_nxt;
            f_pc    <= pc_nxt;
            pend_pc <= pend_nxt;
        end
    end

    assign f_valid = imem_ready && !stall && !reset && (state == ST_RUN);

`ifdef FETCH_ADEL_CHECK_EN
    assign f_exc_adel = (f_pc[1:0] != 2'b00) || (f_pc < IMEM_LO) || (f_pc > IMEM_HI);
`else
    assign f_exc_adel = 1'b0;
`endif

endmodule
